hd_addr_burst_gen: RTL and testbench
====================================

HD_ADDR_BURST_GEN -- requirements
Module: hd_addr_burst_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: width of the effective HD address.
REQ-002 SHALL have parameter PID_W, default 14: width of the pid/base operand.
REQ-003 SHALL have parameter INDEX_W, default 8: width of the index and len operands.
REQ-004 SHALL have parameter SLOT_WORDS, default 40: words per process slot.
REQ-005 SHALL have parameter SR_BASE, default 500: base address of the register-save (SR/LR) region.
REQ-006 SHALL have parameter PAGE_BASE, default 800: base address of the page (store/load page) region.
REQ-007 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1: request pulse, sampled only in IDLE.
REQ-010 SHALL have port mode, input, 2: 0 = copy (raw address), 1 = SR/LR, 2 = store/load page, 3 = illegal.
REQ-011 SHALL have port pid, input, PID_W: raw start address (mode 0) or process id (modes 1/2).
REQ-012 SHALL have port index, input, INDEX_W: word offset within the slot (ignored in mode 0).
REQ-013 SHALL have port len, input, INDEX_W: number of addresses to emit.
REQ-014 SHALL have port addr_out, output, ADDR_W: current effective address.
REQ-015 SHALL have port addr_valid, output, 1: addr_out holds a valid beat.
REQ-016 SHALL have port addr_ready, input, 1: consumer accepts the beat when high with addr_valid.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at request completion.
REQ-019 SHALL have port fault, output, 1: one-cycle pulse coincident with done when the request was rejected.

Function
REQ-020 SHALL implement states IDLE, CALC, BURST, FIN; transitions only on the rising clk edge.
REQ-021 IDLE: on start=1, SHALL latch mode, pid, index, len and go to CALC; start in any other state SHALL be ignored.
REQ-022 CALC (exactly 1 cycle): SHALL compute base = pid (mode 0), SR_BASE + SLOT_WORDS*pid + index (mode 1), PAGE_BASE + SLOT_WORDS*pid + index (mode 2).
REQ-023 The arithmetic SHALL be carried at a width of at least ADDR_W+PID_W+INDEX_W+7 bits, with no truncation before the range checks.
REQ-024 The request SHALL be faulted if mode=3, if base+len-1 > 2^ADDR_W-1 (with len>0), or, in modes 1/2, if index+len > SLOT_WORDS.
REQ-025 From CALC, a faulted request or len=0 SHALL go to FIN with no beats emitted; otherwise it SHALL go to BURST with addr_out=base[ADDR_W-1:0].
REQ-026 BURST: addr_valid SHALL be 1; addr_out and the beat count SHALL be held stable while addr_ready=0.
REQ-027 On a BURST cycle with addr_valid&addr_ready, addr_out SHALL increment by 1 and the remaining count SHALL decrement; on the last beat the block SHALL go to FIN.
REQ-028 The first beat SHALL appear 2 cycles after start is sampled; back-to-back beats at 1 per cycle SHALL be supported when addr_ready stays high.
REQ-029 FIN (1 cycle): done SHALL be 1, fault SHALL be 1 iff the request was rejected, addr_valid SHALL be 0; next state SHALL be IDLE.
REQ-030 A start sampled in the same cycle the block returns to IDLE SHALL be ignored; a new start is accepted only while in IDLE.
REQ-031 addr_out SHALL hold its last value outside BURST; consumers SHALL qualify it with addr_valid.

Reset
REQ-032 When reset=1 at a clk edge, the state SHALL become IDLE and addr_out=0, addr_valid=0, busy=0, done=0, fault=0, with the latched operands and count cleared.
REQ-033 Reset SHALL take priority over start and over any in-flight burst; a burst aborted by reset SHALL produce no done pulse.

Verification
REQ-034 mode=1, pid=2, index=3, len=2, addr_ready=1 -> addr_out 583 then 584 on consecutive cycles, then done=1 with fault=0.
REQ-035 mode=2, pid=0, index=0, len=1, addr_ready held 0 for 3 cycles -> addr_out=800 with addr_valid held for 4 cycles, one beat accepted, then done.
REQ-036 mode=3, or mode=2 with pid=400 (800+16000 > 16383), or mode=1 with index=39 and len=2 -> no addr_valid, done=1 and fault=1 in the same cycle.
REQ-037 mode=0, pid=16383, len=1 -> one beat at 16383 with no fault; with len=2 -> fault.
REQ-038 mode=1, pid=1, index=0, len=5, start held high throughout -> exactly 5 beats 540..544 and one done pulse; start is not re-accepted before IDLE.
REQ-039 reset asserted after the 2nd beat of a len=10 burst -> the next cycle shows addr_valid=0, busy=0, done=0, addr_out=0; a subsequent start runs normally.

Source files
------------

// File: rtl/hd_addr_burst_gen.sv
// HD address burst generator: turns a copy / SR-LR / page request into a
// range-checked run of consecutive addresses handed out under valid/ready.
module hd_addr_burst_gen #(
  parameter int ADDR_W     = 14,
  parameter int PID_W      = 14,
  parameter int INDEX_W    = 8,
  parameter int SLOT_WORDS = 40,
  parameter int SR_BASE    = 500,
  parameter int PAGE_BASE  = 800
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [PID_W-1:0]   pid,
  input  logic [INDEX_W-1:0] index,
  input  logic [INDEX_W-1:0] len,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  // state   | meaning
  // IDLE    | waiting for start; operands latched on start
  // CALC    | one cycle: base address and range checks from latched operands
  // BURST   | addr_valid high, one address per accepted beat
  // FIN     | one cycle: done pulse, fault if the request was rejected

  localparam int CALC_W = ADDR_W + PID_W + INDEX_W + 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_BURST = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         mode_q;
  logic [PID_W-1:0]   pid_q;
  logic [INDEX_W-1:0] index_q;
  logic [INDEX_W-1:0] len_q;
  logic [INDEX_W-1:0] cnt_q;
  logic               fault_q;

  logic [CALC_W-1:0]  slot_off;
  logic [CALC_W-1:0]  base;
  logic [CALC_W-1:0]  end_excl;
  logic [CALC_W-1:0]  slot_end;
  logic               calc_fault;
  logic               skip_burst;

  // Everything is carried wide so an oversized pid cannot wrap past the check.
  always_comb begin
    slot_off = CALC_W'(SLOT_WORDS) * CALC_W'(pid_q) + CALC_W'(index_q);
    case (mode_q)
      2'd0:    base = CALC_W'(pid_q);
      2'd1:    base = CALC_W'(SR_BASE) + slot_off;
      2'd2:    base = CALC_W'(PAGE_BASE) + slot_off;
      default: base = '0;
    endcase
    end_excl   = base + CALC_W'(len_q);
    slot_end   = CALC_W'(index_q) + CALC_W'(len_q);
    calc_fault = (mode_q == 2'd3)
               || ((len_q != '0) && (end_excl > (CALC_W'(1) << ADDR_W)))
               || (((mode_q == 2'd1) || (mode_q == 2'd2)) && (slot_end > CALC_W'(SLOT_WORDS)));
    skip_burst = calc_fault || (len_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    addr_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_CALC;
      end
      S_CALC: begin
        state_d = skip_burst ? S_FIN : S_BURST;
      end
      S_BURST: begin
        addr_valid = 1'b1;
        if (addr_ready && (cnt_q == INDEX_W'(1))) state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        fault   = fault_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Remaining-beat counter runs down to a terminal count of one.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= '0;
      pid_q    <= '0;
      index_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      addr_out <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            pid_q   <= pid;
            index_q <= index;
            len_q   <= len;
          end
        end
        S_CALC: begin
          fault_q <= calc_fault;
          cnt_q   <= len_q;
          if (!skip_burst) addr_out <= base[ADDR_W-1:0];
        end
        S_BURST: begin
          if (addr_ready) begin
            addr_out <= addr_out + ADDR_W'(1);
            cnt_q    <= cnt_q - INDEX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_addr_burst_gen.sv
// Directed bench for hd_addr_burst_gen: drives requests, records beats and
// done/fault pulses at the falling edge, compares with hand-computed values.
module tb_hd_addr_burst_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [13:0] pid;
  logic [7:0]  index;
  logic [7:0]  len;
  logic [13:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        busy;
  logic        done;
  logic        fault;

  int checks = 0;
  int errors = 0;

  int beats[$];
  int valid_cycles, done_cnt, fault_cnt, stray_fault;
  int first_valid, done_at, stable_err;
  logic        prev_valid, prev_acc;
  logic [13:0] prev_addr;

  hd_addr_burst_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .pid       (pid),
    .index     (index),
    .len       (len),
    .addr_out  (addr_out),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input int m, input int p, input int i, input int l);
    @(negedge clk);
    mode  = 2'(m);
    pid   = 14'(p);
    index = 8'(i);
    len   = 8'(l);
    start = 1'b1;
    beats.delete();
    valid_cycles = 0; done_cnt = 0; fault_cnt = 0; stray_fault = 0;
    first_valid = -1; done_at = -1; stable_err = 0;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_addr = '0;
  endtask

  task automatic observe(input int n, input int ready_low, input bit hold_start);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (addr_valid) begin
        if (first_valid < 0) first_valid = c;
        if (prev_valid && !prev_acc && addr_out != prev_addr) stable_err++;
        addr_ready = (valid_cycles >= ready_low);
        valid_cycles++;
        if (addr_ready) beats.push_back(int'(addr_out));
        prev_valid = 1'b1; prev_acc = addr_ready; prev_addr = addr_out;
      end else begin
        addr_ready = 1'b1;
        prev_valid = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        if (fault) fault_cnt++;
        if (hold_start) start = 1'b0;
      end else if (fault) begin
        stray_fault++;
      end
    end
  endtask

  task automatic check_beats(input string tag, input int first, input int n);
    check({tag, "_nbeats"}, beats.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), (i < beats.size()) ? beats[i] : -1, first + i);
  endtask

  task automatic check_fault_req(input string tag);
    check({tag, "_valid"}, valid_cycles, 0);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_fault"}, fault_cnt, 1);
    check({tag, "_stray"}, stray_fault, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; pid = '0; index = '0; len = '0;
    addr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(addr_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_addr", int'(addr_out), 0);
    reset = 1'b0;

    // SR/LR slot: 500 + 40*2 + 3 = 583
    issue(1, 2, 3, 2);
    observe(6, 0, 1'b0);
    check_beats("sr", 583, 2);
    check("sr_latency", first_valid, 2);
    check("sr_done_at", done_at, 4);
    check("sr_done", done_cnt, 1);
    check("sr_fault", fault_cnt, 0);

    // Page with consumer stalling three cycles
    issue(2, 0, 0, 1);
    observe(8, 3, 1'b0);
    check_beats("stall", 800, 1);
    check("stall_valid_cycles", valid_cycles, 4);
    check("stall_stable", stable_err, 0);
    check("stall_done", done_cnt, 1);
    check("stall_fault", fault_cnt, 0);

    issue(3, 5, 0, 1);
    observe(5, 0, 1'b0);
    check_fault_req("mode3");

    // 800 + 40*400 = 16800 exceeds the 14-bit space
    issue(2, 400, 0, 1);
    observe(5, 0, 1'b0);
    check_fault_req("page_range");

    issue(1, 0, 39, 2);
    observe(5, 0, 1'b0);
    check_fault_req("slot_over");

    issue(1, 0, 38, 2);
    observe(6, 0, 1'b0);
    check_beats("slot_edge", 538, 2);
    check("slot_edge_fault", fault_cnt, 0);

    issue(0, 16383, 0, 1);
    observe(5, 0, 1'b0);
    check_beats("copy_top", 16383, 1);
    check("copy_top_fault", fault_cnt, 0);
    check("copy_top_done", done_cnt, 1);

    issue(0, 16383, 0, 2);
    observe(5, 0, 1'b0);
    check_fault_req("copy_wrap");

    issue(0, 10, 0, 0);
    observe(5, 0, 1'b0);
    check("len0_valid", valid_cycles, 0);
    check("len0_done", done_cnt, 1);
    check("len0_fault", fault_cnt, 0);

    // start held high until done: no re-acceptance mid-request
    issue(1, 1, 0, 5);
    observe(12, 0, 1'b1);
    check_beats("held", 540, 5);
    check("held_done", done_cnt, 1);
    check("held_fault", fault_cnt, 0);
    check("held_busy_end", int'(busy), 0);

    // Reset in the middle of a len=10 burst
    issue(0, 100, 0, 10);
    observe(4, 0, 1'b0);
    check_beats("abort_pre", 100, 3);
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", int'(addr_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_addr", int'(addr_out), 0);
    reset = 1'b0;
    observe(4, 0, 1'b0);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_valid", valid_cycles, 3);

    issue(0, 7, 0, 1);
    observe(5, 0, 1'b0);
    check_beats("after_rst", 7, 1);
    check("after_rst_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
